// File: rtl/upc_pkg.sv
// Shared types and item-code bit positions for the checkout lane.
// Also used by the lab display top, which reuses upc_eval.
package upc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    ALARM = 2'd2,
    TOTAL = 2'd3
  } chk_state_t;

  localparam int U_BIT = 2;
  localparam int P_BIT = 1;
  localparam int C_BIT = 0;

endpackage

// File: rtl/upc_eval.sv
// Combinational UPC classifier: discount and stolen flags for one item code.
module upc_eval
  import upc_pkg::*;
(
  input  logic [2:0] upc,
  input  logic       mark,
  output logic       disc,
  output logic       stolen
);

  logic w_u;
  logic w_p;
  logic w_c;

  assign w_u = upc[U_BIT];
  assign w_p = upc[P_BIT];
  assign w_c = upc[C_BIT];

  assign disc   = (w_u & w_c) | w_p;
  assign stolen = ~w_p & ~mark & ~(w_c & ~w_u);

endmodule

// File: rtl/upc_checkout_ctrl.sv
// Checkout lane sequencer: registers each scan, evaluates it a cycle later,
// keeps saturating transaction totals and latches an alarm on stolen items.
module upc_checkout_ctrl
  import upc_pkg::*;
#(
  parameter int COUNT_W       = 8,
  parameter int ALARM_MIN_CYC = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               scan_valid,
  output logic               scan_ready,
  input  logic [2:0]         upc,
  input  logic               mark,
  input  logic               checkout,
  input  logic               clear_alarm,
  output logic               alarm,
  output logic               discount,
  output logic [COUNT_W-1:0] item_count,
  output logic [COUNT_W-1:0] discount_count,
  output logic               done
);

  localparam int                 HOLD_W   = $clog2(ALARM_MIN_CYC + 1);
  localparam logic [HOLD_W-1:0]  HOLD_MIN = HOLD_W'(ALARM_MIN_CYC);
  localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

  chk_state_t         r_state;
  chk_state_t         w_state_next;
  logic [2:0]         r_upc;
  logic               r_mark;
  logic               r_discount;
  logic [COUNT_W-1:0] r_item_count;
  logic [COUNT_W-1:0] r_discount_count;
  logic [HOLD_W-1:0]  r_hold;
  logic               w_disc;
  logic               w_stolen;
  logic               w_hold_met;

  upc_eval u_eval (
    .upc    (r_upc),
    .mark   (r_mark),
    .disc   (w_disc),
    .stolen (w_stolen)
  );

  assign w_hold_met = (r_hold >= HOLD_MIN);

  // A scan presented together with checkout takes priority; checkout is dropped.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (scan_valid)    w_state_next = EVAL;
        else if (checkout) w_state_next = TOTAL;
      end
      EVAL:    w_state_next = w_stolen ? ALARM : IDLE;
      ALARM:   if (clear_alarm && w_hold_met) w_state_next = IDLE;
      TOTAL:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state          <= IDLE;
      r_upc            <= '0;
      r_mark           <= 1'b0;
      r_discount       <= 1'b0;
      r_item_count     <= '0;
      r_discount_count <= '0;
      r_hold           <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (scan_valid) begin
            r_upc  <= upc;
            r_mark <= mark;
          end
        end
        EVAL: begin
          r_hold <= '0;
          if (!w_stolen) begin
            r_discount <= w_disc;
            if (r_item_count != CNT_MAX)
              r_item_count <= r_item_count + 1'b1;
            // Both counters share one ceiling, so discount_count never passes item_count.
            if (w_disc && (r_discount_count != CNT_MAX))
              r_discount_count <= r_discount_count + 1'b1;
          end
        end
        ALARM: begin
          if (!w_hold_met)
            r_hold <= r_hold + 1'b1;
        end
        TOTAL: begin
          r_item_count     <= '0;
          r_discount_count <= '0;
          r_discount       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign scan_ready     = (r_state == IDLE);
  assign alarm          = (r_state == ALARM);
  assign done           = (r_state == TOTAL);
  assign discount       = r_discount;
  assign item_count     = r_item_count;
  assign discount_count = r_discount_count;

endmodule

// File: tb/tb_upc_checkout_ctrl.sv
// Directed bench for upc_checkout_ctrl: default instance plus a COUNT_W=2
// instance for saturation.
module tb_upc_checkout_ctrl;

  logic       clk;
  logic       reset_n;
  logic       scan_valid;
  logic       scan_ready;
  logic [2:0] upc;
  logic       mark;
  logic       checkout;
  logic       clear_alarm;
  logic       alarm;
  logic       discount;
  logic [7:0] item_count;
  logic [7:0] discount_count;
  logic       done;

  logic       b_reset_n;
  logic       b_scan_valid;
  logic       b_scan_ready;
  logic [2:0] b_upc;
  logic       b_mark;
  logic       b_checkout;
  logic       b_clear_alarm;
  logic       b_alarm;
  logic       b_discount;
  logic [1:0] b_item_count;
  logic [1:0] b_discount_count;
  logic       b_done;

  int n_assert;
  int n_fail;

  upc_checkout_ctrl #(.COUNT_W(8), .ALARM_MIN_CYC(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .scan_valid     (scan_valid),
    .scan_ready     (scan_ready),
    .upc            (upc),
    .mark           (mark),
    .checkout       (checkout),
    .clear_alarm    (clear_alarm),
    .alarm          (alarm),
    .discount       (discount),
    .item_count     (item_count),
    .discount_count (discount_count),
    .done           (done)
  );

  upc_checkout_ctrl #(.COUNT_W(2), .ALARM_MIN_CYC(4)) dut_sat (
    .clk            (clk),
    .reset_n        (b_reset_n),
    .scan_valid     (b_scan_valid),
    .scan_ready     (b_scan_ready),
    .upc            (b_upc),
    .mark           (b_mark),
    .checkout       (b_checkout),
    .clear_alarm    (b_clear_alarm),
    .alarm          (b_alarm),
    .discount       (b_discount),
    .item_count     (b_item_count),
    .discount_count (b_discount_count),
    .done           (b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
    $display("check %-24s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic scan(input logic [2:0] code, input logic mk);
    upc        = code;
    mark       = mk;
    scan_valid = 1'b1;
    tick();
    scan_valid = 1'b0;
    tick();
  endtask

  logic [1:0] sat_exp [5];

  initial begin
    n_assert = 0;
    n_fail   = 0;
    sat_exp  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    reset_n = 1'b0; scan_valid = 1'b0; upc = 3'b000; mark = 1'b0;
    checkout = 1'b0; clear_alarm = 1'b0;
    b_reset_n = 1'b0; b_scan_valid = 1'b0; b_upc = 3'b110; b_mark = 1'b1;
    b_checkout = 1'b0; b_clear_alarm = 1'b0;
    tick();
    tick();
    reset_n   = 1'b1;
    b_reset_n = 1'b1;
    check("rst_ready", 32'(scan_ready), 32'd1);
    check("rst_alarm", 32'(alarm), 32'd0);
    check("rst_items", 32'(item_count), 32'd0);
    check("rst_done",  32'(done), 32'd0);

    // Discounted item 010
    upc = 3'b010; mark = 1'b0; scan_valid = 1'b1;
    tick();
    scan_valid = 1'b0;
    check("eval_ready_low", 32'(scan_ready), 32'd0);
    tick();
    check("t2_discount",  32'(discount), 32'd1);
    check("t2_items",     32'(item_count), 32'd1);
    check("t2_disc_cnt",  32'(discount_count), 32'd1);
    check("t2_alarm",     32'(alarm), 32'd0);
    check("t2_ready",     32'(scan_ready), 32'd1);

    // Reset held 2 cycles while a scan is in EVAL
    scan_valid = 1'b1; upc = 3'b010;
    tick();
    scan_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    check("t1_ready",    32'(scan_ready), 32'd1);
    check("t1_items",    32'(item_count), 32'd0);
    check("t1_disc_cnt", 32'(discount_count), 32'd0);
    check("t1_discount", 32'(discount), 32'd0);
    check("t1_alarm",    32'(alarm), 32'd0);

    // Stolen item 000, alarm hold
    scan(3'b000, 1'b0);
    check("t3_alarm",  32'(alarm), 32'd1);
    check("t3_items",  32'(item_count), 32'd0);
    scan_valid = 1'b1; checkout = 1'b1;
    tick();
    scan_valid = 1'b0; checkout = 1'b0;
    tick();
    check("t3_ignore_done", 32'(done), 32'd0);
    clear_alarm = 1'b1;
    tick();
    clear_alarm = 1'b0;
    check("t3_early_clear", 32'(alarm), 32'd1);
    tick();
    clear_alarm = 1'b1;
    tick();
    clear_alarm = 1'b0;
    check("t3_cleared",  32'(alarm), 32'd0);
    check("t3_ready",    32'(scan_ready), 32'd1);
    check("t3_items2",   32'(item_count), 32'd0);

    // Three undiscounted items then checkout
    for (int i = 0; i < 3; i++) scan(3'b001, 1'b0);
    check("t4_items",    32'(item_count), 32'd3);
    check("t4_disc_cnt", 32'(discount_count), 32'd0);
    checkout = 1'b1;
    tick();
    checkout = 1'b0;
    check("t4_done",        32'(done), 32'd1);
    check("t4_total_items", 32'(item_count), 32'd3);
    check("t4_total_disc",  32'(discount_count), 32'd0);
    tick();
    check("t4_done_off",  32'(done), 32'd0);
    check("t4_items_clr", 32'(item_count), 32'd0);
    check("t4_disc_clr",  32'(discount_count), 32'd0);

    // Scan and checkout together: scan wins
    upc = 3'b010; mark = 1'b0; scan_valid = 1'b1; checkout = 1'b1;
    tick();
    scan_valid = 1'b0; checkout = 1'b0;
    check("t6_done_a", 32'(done), 32'd0);
    check("t6_evaling", 32'(scan_ready), 32'd0);
    tick();
    check("t6_done_b", 32'(done), 32'd0);
    check("t6_items",  32'(item_count), 32'd1);

    // Reset during ALARM
    scan(3'b000, 1'b0);
    check("t6_alarm_on", 32'(alarm), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t6_alarm_rst", 32'(alarm), 32'd0);
    check("t6_items_rst", 32'(item_count), 32'd0);

    // COUNT_W=2 saturation
    for (int i = 0; i < 5; i++) begin
      b_scan_valid = 1'b1;
      tick();
      b_scan_valid = 1'b0;
      tick();
      check($sformatf("t5_items_%0d", i), 32'(b_item_count), 32'(sat_exp[i]));
      check($sformatf("t5_disc_%0d", i),  32'(b_discount_count), 32'(sat_exp[i]));
    end
    check("t5_alarm", 32'(b_alarm), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
